// File: rtl/du_word_serializer_pkg.sv
// Shared debug-unit definitions: serializer state encoding, UART byte width,
// pipeline latch-bus widths and the derived maximum transfer length in bytes.
package du_word_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NB_BYTE = 8;

  localparam int NB_IFID  = 64;
  localparam int NB_IDEX  = 130;
  localparam int NB_EXM   = 76;
  localparam int NB_MWB   = 71;
  localparam int NB_R_INT = NB_IFID + NB_IDEX + NB_EXM + NB_MWB;

  function automatic int max_bytes(input int nb_bits);
    return (nb_bits + NB_BYTE - 1) / NB_BYTE;
  endfunction

  localparam int MAX_BYTES = max_bytes(NB_R_INT);

endpackage

// File: rtl/du_word_serializer.sv
// Splits one wide debug snapshot into UART bytes, LSB first, written into the TX FIFO.
// One byte per cycle while the FIFO has room; i_tx_full stalls without losing data.
module du_word_serializer
  import du_word_serializer_pkg::*;
#(
  parameter int NB_DATA = NB_R_INT,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_CNT-1:0]  i_nbytes,
  input  logic               i_abort,
  input  logic               i_tx_full,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_wr,
  output logic               o_busy,
  output logic               o_done
);

  localparam int              N_BYTES  = max_bytes(NB_DATA);
  localparam int              NB_SHIFT = N_BYTES * NB_BYTE;
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(N_BYTES);

  state_e              state_q, state_d;
  logic [NB_SHIFT-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                wr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wr        = 1'b0;
    o_tx_data = '0;
    o_tx_wr   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;

    case (state_q)
      IDLE: begin
        // Abort has priority over a coincident start.
        if (i_start && !i_abort) begin
          if (i_nbytes == '0) begin
            state_d = DONE;
          end else begin
            shift_d                = '0;
            shift_d[NB_DATA-1:0]   = i_data;
            cnt_d                  = (i_nbytes > CNT_MAX) ? CNT_MAX : i_nbytes;
            state_d                = SEND;
          end
        end
      end

      SEND: begin
        o_busy    = 1'b1;
        o_tx_data = shift_q[NB_BYTE-1:0];
        wr        = ~i_tx_full;
        o_tx_wr   = wr;
        if (wr) begin
          shift_d = shift_q >> NB_BYTE;
          cnt_d   = cnt_q - NB_CNT'(1);
          if (cnt_q == NB_CNT'(1)) begin
            state_d = DONE;
          end
        end
        // The byte presented this cycle is still written when aborting.
        if (i_abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      DONE: begin
        o_busy  = 1'b1;
        o_done  = ~i_abort;
        state_d = IDLE;
        if (i_abort) begin
          cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
